// File: rtl/cordic_iterative_engine.sv
// Iterative CORDIC engine: one shared add/shift stage reused per micro-rotation,
// with quadrant pre-correction at load and saturated, handshaked results.
module cordic_iterative_engine #(
   parameter int WIDTH = 24,
   parameter int ITER  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    mode_i,
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] y_i,
   input  logic signed [WIDTH-1:0] z_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] x_o,
   output logic signed [WIDTH-1:0] y_o,
   output logic signed [WIDTH-1:0] z_o
);

   localparam int XW = WIDTH + 2;
   localparam int SH = 32 - WIDTH;

   localparam logic signed [WIDTH-1:0] QUARTER     = {2'b01, {(WIDTH-2){1'b0}}};
   localparam logic signed [WIDTH-1:0] NEG_QUARTER = -QUARTER;
   localparam logic signed [WIDTH-1:0] SAT_HI      = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0]    SAT_HI_X    = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0]    SAT_LO_X    = -SAT_HI_X;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // atan(2^-i) scaled so that 2^31 represents pi.
   function automatic logic [31:0] atan32(input int idx);
      logic [31:0] v;
      case (idx)
         0:  v = 32'h20000000;
         1:  v = 32'h12E4051E;
         2:  v = 32'h09FB385B;
         3:  v = 32'h051111D4;
         4:  v = 32'h028B0D43;
         5:  v = 32'h0145D7E1;
         6:  v = 32'h00A2F61E;
         7:  v = 32'h00517C55;
         8:  v = 32'h0028BE53;
         9:  v = 32'h00145F2F;
         10: v = 32'h000A2F98;
         11: v = 32'h000517CC;
         12: v = 32'h00028BE6;
         13: v = 32'h000145F3;
         14: v = 32'h0000A2F9;
         15: v = 32'h0000517C;
         16: v = 32'h000028BE;
         17: v = 32'h0000145F;
         18: v = 32'h00000A2F;
         19: v = 32'h00000517;
         20: v = 32'h0000028B;
         21: v = 32'h00000145;
         22: v = 32'h000000A2;
         23: v = 32'h00000051;
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
      logic signed [WIDTH-1:0] r;
      r = v[WIDTH-1:0];
      if (v > SAT_HI_X)
         r = SAT_HI;
      else if (v < SAT_LO_X)
         r = -SAT_HI;
      return r;
   endfunction

   logic signed [WIDTH-1:0] atan_tab [24];

   // Table reduced to WIDTH bits with round-half-up at elaboration time.
   generate
      for (genvar gi = 0; gi < 24; gi++) begin : g_rom
         localparam logic [32:0] RAW = {1'b0, atan32(gi)};
         localparam logic [32:0] RND = (33'd1 << SH) >> 1;
         localparam logic [32:0] RED = (RAW + RND) >> SH;
         assign atan_tab[gi] = RED[WIDTH-1:0];
      end
   endgenerate

   state_t                  state_q, state_d;
   logic [4:0]              cnt_q, cnt_d;
   logic                    mode_q, mode_d;
   logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
   logic signed [WIDTH-1:0] z_q, z_d;
   logic signed [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

   logic                    accept;
   logic signed [XW-1:0]    x_ext, y_ext, x_ld, y_ld;
   logic signed [WIDTH-1:0] z_ld;
   logic                    d_pos;
   logic signed [XW-1:0]    x_sh, y_sh, x_it, y_it;
   logic signed [WIDTH-1:0] atan_i, z_it;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;

   assign x_ext = {{2{x_i[WIDTH-1]}}, x_i};
   assign y_ext = {{2{y_i[WIDTH-1]}}, y_i};

   // Fold the operand into the right half-plane so the micro-rotations converge.
   always_comb begin
      x_ld = x_ext;
      y_ld = y_ext;
      z_ld = z_i;
      if (!mode_i) begin
         if (z_i > QUARTER) begin
            x_ld = -y_ext;
            y_ld = x_ext;
            z_ld = z_i - QUARTER;
         end else if (z_i < NEG_QUARTER) begin
            x_ld = y_ext;
            y_ld = -x_ext;
            z_ld = z_i + QUARTER;
         end
      end else if (x_i[WIDTH-1]) begin
         if (!y_i[WIDTH-1]) begin
            x_ld = y_ext;
            y_ld = -x_ext;
            z_ld = z_i + QUARTER;
         end else begin
            x_ld = -y_ext;
            y_ld = x_ext;
            z_ld = z_i - QUARTER;
         end
      end
   end

   assign d_pos  = mode_q ? y_q[XW-1] : ~z_q[WIDTH-1];
   assign x_sh   = x_q >>> cnt_q;
   assign y_sh   = y_q >>> cnt_q;
   assign atan_i = atan_tab[cnt_q];
   assign x_it   = d_pos ? (x_q - y_sh) : (x_q + y_sh);
   assign y_it   = d_pos ? (y_q + x_sh) : (y_q - x_sh);
   assign z_it   = d_pos ? (z_q - atan_i) : (z_q + atan_i);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      xo_d    = xo_q;
      yo_d    = yo_q;
      zo_d    = zo_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               cnt_d   = '0;
               mode_d  = mode_i;
               x_d     = x_ld;
               y_d     = y_ld;
               z_d     = z_ld;
            end
         end
         RUN: begin
            x_d = x_it;
            y_d = y_it;
            z_d = z_it;
            if (cnt_q == 5'(ITER - 1)) begin
               state_d = DONE;
               xo_d    = sat(x_it);
               yo_d    = sat(y_it);
               zo_d    = z_it;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         DONE: begin
            if (accept) begin
               state_d = RUN;
               cnt_d   = '0;
               mode_d  = mode_i;
               x_d     = x_ld;
               y_d     = y_ld;
               z_d     = z_ld;
            end else if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         xo_q    <= '0;
         yo_q    <= '0;
         zo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         xo_q    <= xo_d;
         yo_q    <= yo_d;
         zo_q    <= zo_d;
      end
   end

   assign x_o = xo_q;
   assign y_o = yo_q;
   assign z_o = zo_q;

endmodule

// File: tb/tb_cordic_iterative_engine.sv
// Directed and randomized checks of cordic_iterative_engine (WIDTH=24, ITER=16)
// against an integer-arithmetic reference of the CORDIC rules.
module tb_cordic_iterative_engine;

   localparam int W = 24;
   localparam int N = 16;
   localparam longint HALF  = 64'sd1 << (W - 1);
   localparam longint FULL  = 64'sd1 << W;
   localparam longint QUART = 64'sd1 << (W - 2);
   localparam longint SMAX  = HALF - 1;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic                mode_i = 1'b0;
   logic signed [W-1:0] x_i = '0, y_i = '0, z_i = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] x_o, y_o, z_o;

   int n_cmp = 0;
   int n_bad = 0;

   longint atan32 [24] = '{
      64'h20000000, 64'h12E4051E, 64'h09FB385B, 64'h051111D4,
      64'h028B0D43, 64'h0145D7E1, 64'h00A2F61E, 64'h00517C55,
      64'h0028BE53, 64'h00145F2F, 64'h000A2F98, 64'h000517CC,
      64'h00028BE6, 64'h000145F3, 64'h0000A2F9, 64'h0000517C,
      64'h000028BE, 64'h0000145F, 64'h00000A2F, 64'h00000517,
      64'h0000028B, 64'h00000145, 64'h000000A2, 64'h00000051};

   cordic_iterative_engine #(.WIDTH(W), .ITER(N)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .mode_i(mode_i), .x_i(x_i), .y_i(y_i), .z_i(z_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_o(x_o), .y_o(y_o), .z_o(z_o));

   always #5 clk = ~clk;

   function automatic longint wrapw(input longint v);
      longint r;
      r = v & (FULL - 1);
      if (r >= HALF) r = r - FULL;
      return r;
   endfunction

   function automatic longint satw(input longint v);
      if (v > SMAX) return SMAX;
      if (v < -SMAX) return -SMAX;
      return v;
   endfunction

   function automatic longint sx(input logic [W-1:0] v);
      return longint'($signed(v));
   endfunction

   // Reference: half-plane fold, then N shift-add micro-rotations on unbounded integers.
   function automatic void ref_model(input bit m, input longint x, input longint y, input longint z,
                                     output longint xr, output longint yr, output longint zr);
      longint xs, ys, zs, t, a, xn;
      xs = x; ys = y; zs = z;
      if (!m) begin
         if (zs > QUART) begin t = xs; xs = -ys; ys = t; zs = zs - QUART; end
         else if (zs < -QUART) begin t = xs; xs = ys; ys = -t; zs = zs + QUART; end
      end else if (xs < 0) begin
         t = xs;
         if (ys >= 0) begin xs = ys; ys = -t; zs = zs + QUART; end
         else begin xs = -ys; ys = t; zs = zs - QUART; end
      end
      zs = wrapw(zs);
      for (int i = 0; i < N; i++) begin
         a = (atan32[i] + (64'sd1 << (31 - W))) >>> (32 - W);
         if (m ? (ys < 0) : (zs >= 0)) begin
            xn = xs - (ys >>> i); ys = ys + (xs >>> i); zs = wrapw(zs - a);
         end else begin
            xn = xs + (ys >>> i); ys = ys - (xs >>> i); zs = wrapw(zs + a);
         end
         xs = xn;
      end
      xr = satw(xs); yr = satw(ys); zr = zs;
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_tol(input string tag, input longint obs, input longint exp,
                            input longint tol, input bit wrapped);
      longint diff;
      bit ok;
      diff = obs - exp;
      if (wrapped) diff = wrapw(diff);
      ok = (diff <= tol) && (diff >= -tol);
      n_cmp++;
      assert (ok) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
      end
   endtask

   task automatic drive_op(input bit m, input longint x, input longint y, input longint z);
      mode_i = m;
      x_i = x[W-1:0];
      y_i = y[W-1:0];
      z_i = z[W-1:0];
   endtask

   task automatic launch(input string tag, input bit m, input longint x, input longint y, input longint z);
      int k;
      drive_op(m, x, y, z);
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
      check({tag, "_in_ready"}, longint'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic expect_exact(input string tag, input bit m, input longint x, input longint y, input longint z);
      longint xr, yr, zr;
      ref_model(m, x, y, z, xr, yr, zr);
      $display("op %s mode=%0d x=%0d y=%0d z=%0d -> x_o=%0d y_o=%0d z_o=%0d (ref %0d %0d %0d)",
               tag, m, x, y, z, sx(x_o), sx(y_o), sx(z_o), xr, yr, zr);
      check({tag, "_x"}, sx(x_o), xr);
      check({tag, "_y"}, sx(y_o), yr);
      check({tag, "_z"}, sx(z_o), zr);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_drained"}, longint'(out_valid), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lat;
      longint rx, ry, rz, px, py, pz;
      bit rm;

      // Reset state
      #12;
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_x", sx(x_o), 0);
      check("rst_y", sx(y_o), 0);
      check("rst_z", sx(z_o), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Rotation by 45 degrees
      launch("rot45", 1'b0, 1048576, 0, 2097152);
      wait_result(lat);
      check("rot45_latency", lat, N);
      check_tol("rot45_xtol", sx(x_o), 1220998, 64, 1'b0);
      check_tol("rot45_ytol", sx(y_o), 1220998, 64, 1'b0);
      expect_exact("rot45", 1'b0, 1048576, 0, 2097152);
      drain("rot45");

      // Vectoring of a vector on the negative x axis
      launch("vec180", 1'b1, -1048576, 0, 0);
      wait_result(lat);
      check("vec180_latency", lat, N);
      check_tol("vec180_xtol", sx(x_o), 1726745, 64, 1'b0);
      check_tol("vec180_ytol", sx(y_o), 0, 64, 1'b0);
      check_tol("vec180_ztol", sx(z_o), -8388608, 128, 1'b1);
      expect_exact("vec180", 1'b1, -1048576, 0, 0);
      drain("vec180");

      // Saturation
      launch("sat", 1'b0, 8388607, 8388607, 0);
      wait_result(lat);
      check("sat_latency", lat, N);
      check("sat_x", sx(x_o), 8388607);
      check("sat_y", sx(y_o), 8388607);
      drain("sat");

      // Backpressure with a new operand waiting
      launch("bp_a", 1'b0, 3000000, -2000000, -6000000);
      wait_result(lat);
      check("bp_a_latency", lat, N);
      expect_exact("bp_a", 1'b0, 3000000, -2000000, -6000000);
      px = sx(x_o); py = sx(y_o); pz = sx(z_o);
      drive_op(1'b1, -500000, -700000, 12345);
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d_valid", c), longint'(out_valid), 1);
         check($sformatf("bp_hold%0d_ready", c), longint'(in_ready), 0);
         check($sformatf("bp_hold%0d_x", c), sx(x_o), px);
         check($sformatf("bp_hold%0d_y", c), sx(y_o), py);
         check($sformatf("bp_hold%0d_z", c), sx(z_o), pz);
      end
      out_ready = 1'b1;
      #1;
      check("bp_ready_release", longint'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("bp_b_running", longint'(out_valid), 0);
      check("bp_b_busy", longint'(in_ready), 0);
      wait_result(lat);
      check("bp_b_latency", lat, N);
      expect_exact("bp_b", 1'b1, -500000, -700000, 12345);
      drain("bp_b");

      // Reset in the middle of a run
      launch("rst_mid", 1'b0, 2500000, 1500000, 5000000);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rstmid_x", sx(x_o), 0);
      check("rstmid_y", sx(y_o), 0);
      check("rstmid_z", sx(z_o), 0);
      check("rstmid_valid", longint'(out_valid), 0);
      check("rstmid_ready", longint'(in_ready), 1);
      #2;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rstmid_idle_valid", longint'(out_valid), 0);
      launch("post_rst", 1'b1, 4000000, -3000000, -100);
      wait_result(lat);
      check("post_rst_latency", lat, N);
      expect_exact("post_rst", 1'b1, 4000000, -3000000, -100);
      drain("post_rst");

      // in_valid pulses during RUN are ignored
      launch("stall", 1'b0, -1234567, 765432, 7000000);
      lat = 0;
      while (!out_valid && lat < 40) begin
         in_valid = (lat == 3) || (lat == 8);
         if (in_valid) drive_op(1'b1, 111111, 222222, 333333);
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check("stall_latency", lat, N);
      expect_exact("stall", 1'b0, -1234567, 765432, 7000000);
      out_ready = 1'b1;
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      out_ready = 1'b0;
      check("stall_extra_results", lat, 0);

      // Back-to-back throughput with out_ready held high
      out_ready = 1'b1;
      launch("thru", 1'b0, 1000000, 1000000, 1000000);
      in_valid = 1'b1;
      wait_result(lat);
      check("thru_first_latency", lat, N);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 60);
      check("thru_period", lat, N + 1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("thru_idle", longint'(out_valid), 0);

      // Randomized operands against the reference model
      for (int t = 0; t < 24; t++) begin
         rm = 1'($urandom_range(0, 1));
         rx = wrapw(longint'($urandom));
         ry = wrapw(longint'($urandom));
         rz = wrapw(longint'($urandom));
         launch($sformatf("rnd%0d", t), rm, rx, ry, rz);
         wait_result(lat);
         check($sformatf("rnd%0d_latency", t), lat, N);
         expect_exact($sformatf("rnd%0d", t), rm, rx, ry, rz);
         drain($sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
